cell_truth_sequencer: RTL and testbench
=======================================

Name: cell_truth_sequencer

Overview:
- Self-checking stimulus controller for a single-output combinational standard cell under test (CUT), e.g. OAI21_X1.
- Walks every input vector 0..2^N_IN-1 into the CUT and waits a fixed settle time per vector.
- Samples the CUT output and compares it against a parameterised golden truth table.
- Reports mismatches, the first failing vector and a per-vector log strobe; replaces hand-written delay/display stimulus in cell benches.

Parameters:
- N_IN, 3, number of CUT inputs (1..6); vector bit N_IN-1 drives the first-listed cell pin (A for OAI21).
- SETTLE, 2, clock cycles between applying a vector and sampling cut_out (>=1).
- TRUTH, 8'h1F, golden table, width 2^N_IN; bit i = expected output for vector i (8'h1F = OAI21: ZN=~(A&(B1|B2))).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the run; sampled in any state.
- cut_in  out  N_IN  registered stimulus vector to the CUT.
- cut_out  in  1  CUT output.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse when a run completes normally.
- pass  out  1  level; 1 when the last completed run had zero mismatches.
- err_count  out  N_IN+1  mismatches in the current/last run.
- fail_valid  out  1  a mismatch has been recorded this run.
- fail_vec  out  N_IN  first mismatching vector.
- log_valid  out  1  one-cycle pulse per sampled vector.
- log_vec  out  N_IN  vector just sampled.
- log_got  out  1  cut_out value sampled for log_vec.
- log_exp  out  1  TRUTH[log_vec].

Behaviour:
- Reset (rst_n=0, async): state IDLE; every output 0, including cut_in, pass, err_count and fail_vec.
- States: IDLE, WAIT, DONE.
- IDLE, start=1 at edge E0:
  - vec<=0, cut_in<=0, settle counter<=SETTLE-1.
  - err_count, fail_valid, fail_vec and pass cleared.
  - busy<=1; next state WAIT.
- WAIT:
  - Counter decrements each edge.
  - The edge at which the counter is 0 is the sample edge, exactly SETTLE cycles after cut_in last changed.
- Sample edge:
  - mismatch = (cut_out !== TRUTH[vec]); X/Z on cut_out counts as a mismatch.
  - err_count += mismatch. If mismatch and !fail_valid: fail_vec<=vec, fail_valid<=1.
  - log_valid<=1 with log_vec=vec, log_got=cut_out, log_exp=TRUTH[vec], all visible the following cycle.
  - If vec != 2^N_IN-1: vec<=vec+1, cut_in<=vec+1 on the same edge, counter reloads to SETTLE-1.
  - Else: next state DONE, cut_in holds its last value.
- DONE (one cycle): done=1; busy<=0 at the next edge; pass<=(err_count==0); next state IDLE.
- Timing: done is high in the cycle starting 2^N_IN*SETTLE edges after E0 (8*2=16 with defaults).
- start while busy: ignored, no restart.
- abort (any non-IDLE state): next edge returns to IDLE.
  - cut_in<=0, busy<=0, pass<=0, no done pulse.
  - err_count and fail_* hold their partial values.
- start and abort both high in IDLE: abort wins, stays IDLE.
- Reset mid-run: immediate return to IDLE with all outputs 0, no done pulse.
- err_count never wraps: maximum is 2^N_IN, which fits N_IN+1 bits.
- Outputs hold their values in IDLE until the next start.

Decomposition:
- Shared package cell_tb_pkg: state encoding localparams (IDLE/WAIT/DONE), OAI21/AOI21/NAND2/NOR2 truth-table constants, log-format constants.
- One natural sub-module, settle_timer: loadable down-counter with zero flag, width clog2(SETTLE).
- Compare/log logic stays in the top level.

Test Plan:
- Golden OAI21 model, defaults, start pulse -> log sequence vec 0..7 with got 1,1,1,1,1,0,0,0; done at edge 16 after start; pass=1; err_count=0; fail_valid=0.
- CUT with ZN stuck-at-1 -> err_count=3, fail_vec=5, fail_valid=1, pass=0, done still at edge 16.
- abort asserted while log_vec=3 -> next cycle busy=0, cut_in=0, no done pulse; err_count holds its partial value; a new start then completes with pass=1.
- start re-pulsed at vector 4 -> ignored, run continues; single done at edge 16.
- cut_out driven X for vector 2; separately, rst_n low at vector 6 -> X gives err_count=1, fail_vec=2; reset gives all outputs 0 immediately, no done.
- SETTLE=1, N_IN=2, TRUTH=4'h7 (NAND2) -> cut_in changes every cycle 0,1,2,3; done at edge 4; pass=1.

Source files
------------

// File: rtl/cell_truth_sequencer_pkg.sv
// cell_tb_pkg: shared state encoding, golden cell truth tables and log-record
// constants for the cell truth sequencer.
package cell_tb_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   localparam logic [7:0] TRUTH_OAI21 = 8'h1F;
   localparam logic [7:0] TRUTH_AOI21 = 8'h07;
   localparam logic [3:0] TRUTH_NAND2 = 4'h7;
   localparam logic [3:0] TRUTH_NOR2  = 4'h1;
   // a log record is log_vec followed by the got/exp bit pair
   localparam int LOG_FLAG_W = 2;
   function automatic int n_vectors(input int n_in);
      return 1 << n_in;
   endfunction
endpackage

// File: rtl/cell_truth_sequencer_if.sv
// cell_truth_sequencer_if: run control, CUT stimulus/response and result/log bus.
interface cell_truth_sequencer_if #(parameter int N_IN = 3);
   logic            start, abort, cut_out;
   logic [N_IN-1:0] cut_in;
   logic            busy, done, pass, fail_valid;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] fail_vec, log_vec;
   logic            log_valid, log_got, log_exp;
   modport master(
      output start, abort, cut_out,
      input  cut_in, busy, done, pass, err_count, fail_valid, fail_vec,
             log_valid, log_vec, log_got, log_exp
   );
   modport slave(
      input  start, abort, cut_out,
      output cut_in, busy, done, pass, err_count, fail_valid, fail_vec,
             log_valid, log_vec, log_got, log_exp
   );
endinterface

// File: rtl/cell_truth_sequencer_settle_timer.sv
// settle_timer: loadable down-counter that stops at zero and flags it.
module settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);
   localparam int W = SETTLE > 1 ? $clog2(SETTLE) : 1;
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= W'(SETTLE - 1);
      else if (dec && cnt != '0) cnt <= cnt - 1'b1;
   end
   assign zero = cnt == '0;
endmodule

// File: rtl/cell_truth_sequencer.sv
// cell_truth_sequencer: walks every input vector through a combinational cell and
// checks each settled response against a golden truth table.
module cell_truth_sequencer
   import cell_tb_pkg::*;
#(
   parameter int N_IN = 3,
   parameter int SETTLE = 2,
   parameter logic [n_vectors(N_IN)-1:0] TRUTH = TRUTH_OAI21
) (
   input logic clk,
   input logic rst_n,
   cell_truth_sequencer_if.slave bus
);
   state_t          state;
   logic [N_IN-1:0] vec;
   logic            tmr_zero, sample, mismatch, tmr_load;
   assign sample   = state == WAIT && tmr_zero;
   // case inequality so an X/Z response is reported rather than masked
   assign mismatch = bus.cut_out !== TRUTH[vec];
   assign tmr_load = !bus.abort && ((state == IDLE && bus.start) || (sample && vec != '1));
   settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk(clk), .rst_n(rst_n), .load(tmr_load), .dec(state == WAIT), .zero(tmr_zero)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         vec            <= '0;
         bus.cut_in     <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.pass       <= 1'b0;
         bus.err_count  <= '0;
         bus.fail_valid <= 1'b0;
         bus.fail_vec   <= '0;
         bus.log_valid  <= 1'b0;
         bus.log_vec    <= '0;
         bus.log_got    <= 1'b0;
         bus.log_exp    <= 1'b0;
      end else begin
         bus.done      <= 1'b0;
         bus.log_valid <= 1'b0;
         if (bus.abort) begin
            if (state != IDLE) begin
               state      <= IDLE;
               bus.cut_in <= '0;
               bus.busy   <= 1'b0;
               bus.pass   <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: if (bus.start) begin
                  state          <= WAIT;
                  vec            <= '0;
                  bus.cut_in     <= '0;
                  bus.busy       <= 1'b1;
                  bus.pass       <= 1'b0;
                  bus.err_count  <= '0;
                  bus.fail_valid <= 1'b0;
                  bus.fail_vec   <= '0;
               end
               WAIT: if (tmr_zero) begin
                  bus.err_count <= bus.err_count + {{N_IN{1'b0}}, mismatch};
                  if (mismatch && !bus.fail_valid) begin
                     bus.fail_vec   <= vec;
                     bus.fail_valid <= 1'b1;
                  end
                  bus.log_valid <= 1'b1;
                  bus.log_vec   <= vec;
                  bus.log_got   <= bus.cut_out;
                  bus.log_exp   <= TRUTH[vec];
                  if (vec != '1) begin
                     vec        <= vec + 1'b1;
                     bus.cut_in <= vec + 1'b1;
                  end else begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end
               end
               DONE: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  bus.pass <= bus.err_count == '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cell_truth_sequencer.sv
// tb_cell_truth_sequencer: randomized runs against a truth-table CUT model with a
// queue scoreboard; a second instance covers the NAND2 / SETTLE=1 configuration.
module tb_cell_truth_sequencer;
   import cell_tb_pkg::*;

   typedef struct {int cyc; int vec; logic got; logic exp; int cin;} log_t;
   typedef struct {int cyc; int err; logic fvalid; int fvec; logic pass;} done_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0, n_fail = 0;
   logic [7:0] gold = 8'h1F;
   logic [7:0] cut_tab = 8'h1F;
   logic [7:0] cut_xm = 8'h00;
   logic [3:0] nand_tab = 4'h7;
   logic       xbit;
   log_t  exp_log[$];
   done_t exp_done[$];
   log_t  l;
   done_t d;
   logic  pend = 1'b0, pend_pass = 1'b0;

   cell_truth_sequencer_if #(.N_IN(3)) b();
   cell_truth_sequencer_if #(.N_IN(2)) b2();

   cell_truth_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(b));
   cell_truth_sequencer #(.N_IN(2), .SETTLE(1), .TRUTH(TRUTH_NAND2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(b2)
   );

   assign b.cut_out  = cut_xm[b.cut_in] ? xbit : cut_tab[b.cut_in];
   assign b2.cut_out = nand_tab[b2.cut_in];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic cut_fn(input int v);
      return cut_xm[v] ? xbit : cut_tab[v];
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (pend) begin
         chk("pass_after_done", b.pass, pend_pass);
         chk("busy_after_done", b.busy, 0);
         pend = 1'b0;
      end
      if (b.log_valid) begin
         chk("log_expected", exp_log.size() > 0, 1);
         if (exp_log.size() > 0) begin
            l = exp_log.pop_front();
            chk("log_cycle", cyc, l.cyc);
            chk("log_vec", b.log_vec, l.vec);
            chk("log_got", b.log_got, l.got);
            chk("log_exp", b.log_exp, l.exp);
            chk("log_cut_in", b.cut_in, l.cin);
         end
      end
      if (b.done) begin
         chk("done_expected", exp_done.size() > 0, 1);
         if (exp_done.size() > 0) begin
            d = exp_done.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("err_count", b.err_count, d.err);
            chk("fail_valid", b.fail_valid, d.fvalid);
            if (d.fvalid) chk("fail_vec", b.fail_vec, d.fvec);
            chk("busy_at_done", b.busy, 1);
            pend = 1'b1;
            pend_pass = d.pass;
         end
      end
   end

   // one run: abort_k/rst_k stop the run after that many logs, restart_k re-pulses start
   task automatic run(input logic [7:0] tab, input logic [7:0] xm, input int abort_k,
                      input int rst_k, input int restart_k);
      int e0, stop, err, fvec;
      logic fvalid, g;
      cut_tab = tab;
      cut_xm = xm;
      @(negedge clk);
      e0 = cyc + 1;
      stop = abort_k != 0 ? abort_k : rst_k != 0 ? rst_k : 8;
      err = 0; fvec = 0; fvalid = 1'b0;
      for (int v = 0; v < stop; v++) begin
         g = cut_fn(v);
         exp_log.push_back('{e0 + 2 * (v + 1), v, g, gold[v], v < 7 ? v + 1 : 7});
         if (g !== gold[v]) begin
            err++;
            if (!fvalid) begin fvec = v; fvalid = 1'b1; end
         end
      end
      if (stop == 8) exp_done.push_back('{e0 + 16, err, fvalid, fvec, err == 0});
      b.start = 1'b1;
      @(negedge clk);
      b.start = 1'b0;
      chk("busy_after_start", b.busy, 1);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (abort_k != 0 && c == 2 * abort_k) b.abort = 1'b1;
         if (abort_k != 0 && c == 2 * abort_k + 1) begin
            b.abort = 1'b0;
            chk("abort_busy", b.busy, 0);
            chk("abort_cut_in", b.cut_in, 0);
            chk("abort_err_hold", b.err_count, err);
            chk("abort_fail_valid", b.fail_valid, fvalid);
            chk("abort_pass", b.pass, 0);
         end
         if (restart_k != 0 && c == 2 * restart_k) b.start = 1'b1;
         if (restart_k != 0 && c == 2 * restart_k + 1) b.start = 1'b0;
         if (rst_k != 0 && c == 2 * rst_k) begin
            chk("cut_in_before_reset", b.cut_in, rst_k);
            #2 rst_n = 1'b0;
            #1 chk("reset_mid_run", {b.busy, b.done, b.pass, b.cut_in, b.err_count, b.fail_valid,
                                     b.fail_vec, b.log_valid, b.log_vec, b.log_got, b.log_exp}, 0);
         end
         if (rst_k != 0 && c == 2 * rst_k + 1) rst_n = 1'b1;
      end
      chk("queues_drained", exp_log.size() + exp_done.size(), 0);
      cut_xm = 8'h00;
   endtask

   initial begin
      xbit = 1'bx;
      b.start = 1'b0; b.abort = 1'b0;
      b2.start = 1'b0; b2.abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {b.busy, b.done, b.pass, b.cut_in, b.err_count, b.fail_valid,
                            b.fail_vec, b.log_valid, b.log_vec, b.log_got, b.log_exp}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      b.start = 1'b1; b.abort = 1'b1;
      @(negedge clk);
      b.start = 1'b0; b.abort = 1'b0;
      chk("start_abort_idle", b.busy, 0);
      run(8'h1F, 8'h00, 0, 0, 0);
      run(8'hFF, 8'h00, 0, 0, 0);
      chk("stuck1_fail_vec", b.fail_vec, 5);
      chk("stuck1_err_count", b.err_count, 3);
      run(8'h1D, 8'h00, 4, 0, 0);
      run(8'h1F, 8'h00, 0, 0, 0);
      run(8'h1F, 8'h00, 0, 0, 4);
      run(8'h1F, 8'h04, 0, 0, 0);
      run(8'h1F, 8'h00, 0, 6, 0);
      for (int i = 0; i < 8; i++)
         run(8'($urandom_range(0, 255)),
             $urandom_range(0, 3) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
             $urandom_range(0, 2) == 0 ? $urandom_range(1, 7) : 0, 0, 0);
      @(negedge clk);
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      chk("nand2_cut_in_0", b2.cut_in, 0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("nand2_cut_in", b2.cut_in, i);
         chk("nand2_no_early_done", b2.done, 0);
      end
      @(negedge clk);
      chk("nand2_done_edge4", b2.done, 1);
      @(negedge clk);
      chk("nand2_pass", b2.pass, 1);
      chk("nand2_err_count", b2.err_count, 0);
      chk("nand2_busy_low", b2.busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
